ftw_load_ctrl: RTL and testbench

Load controller for the 48-bit DDS frequency tuning word (FTW) register. It accepts the FTW from the 16-bit host write port as three successive words and assembles them. It then issues a single-cycle commit strobe so the 48-bit latch updates atomically and never holds a half-written word. It sits between the host interface and the FTW latch's Din/EN inputs.

---
 rtl/ftw_load_ctrl_pkg.sv | 17 +
 rtl/ftw_load_ctrl_if.sv | 16 +
 rtl/ftw_load_ctrl_word_timeout_cnt.sv | 39 +++
 rtl/ftw_load_ctrl.sv | 158 +++++++++++++++
 tb/tb_ftw_load_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ftw_load_ctrl_pkg.sv
// rtl/ftw_load_ctrl_pkg.sv - shared types and width defaults for the FTW load controller
// Purpose : controller state encoding and default widths shared by the
//           controller, its host write interface and the watchdog.
// Ports   : none (package).
package ftw_ctrl_pkg;
   localparam int WORD_W_DEF  = 16;
   localparam int NWORDS_DEF  = 3;
   localparam int FTW_W_DEF   = WORD_W_DEF * NWORDS_DEF;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      ARMED   = 2'd2,
      COMMIT  = 2'd3
   } ftw_state_e;
endpackage

// File: rtl/ftw_load_ctrl_if.sv
// rtl/ftw_load_ctrl_if.sv - host write port bundle for the FTW load controller
// Purpose : groups the host word handshake (data/valid/ready).
// Ports   : master modport = host side (drives wr_data, wr_valid; sees wr_ready)
//           slave  modport = controller side (sees wr_data, wr_valid; drives wr_ready)
interface ftw_load_ctrl_if
   import ftw_ctrl_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
);
   logic [WORD_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;

   modport master (output wr_data, output wr_valid, input wr_ready);
   modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/ftw_load_ctrl_word_timeout_cnt.sv
// rtl/ftw_load_ctrl_word_timeout_cnt.sv - inter-word watchdog for the FTW load controller
// Purpose : counts consecutive idle cycles between words of one FTW.
// Ports   : clk, rst_n (async, active-low)
//           clr_i - restart the count from zero
//           en_i  - one more idle cycle elapsed
//           tc_o  - combinational pulse on the TIMEOUT-th consecutive idle cycle
module word_timeout_cnt #(
   parameter  int TIMEOUT = 255,
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q holds the idle cycles already seen, so the current idle cycle is
   // the TIMEOUT-th one when cnt_q is TIMEOUT-1.
   assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tc_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/ftw_load_ctrl.sv
// rtl/ftw_load_ctrl.sv - assembles a 48-bit FTW from host words and commits it atomically
// Purpose : collects NWORDS host words (least-significant first) into ftw_out_o
//           and issues a one-cycle ftw_en_o so the downstream latch updates atomically.
// Config  : FTW_SYNC_COMMIT_EN - when defined, wait in ARMED for sync_pulse_i
//           before committing; when undefined the last word commits directly.
// Ports   : clk, rst_n     - clock, async active-low reset
//           wr_if          - host word handshake (slave modport)
//           abort_i        - drop the partial FTW (COLLECT/ARMED only)
//           sync_pulse_i   - commit qualifier (only with FTW_SYNC_COMMIT_EN)
//           ftw_out_o      - assembled FTW, valid while ftw_en_o=1
//           ftw_en_o       - one-cycle commit strobe
//           busy_o         - state is not IDLE
//           err_timeout_o  - one-cycle pulse on inter-word timeout
//           commit_cnt_o   - wrapping commit count
module ftw_load_ctrl
   import ftw_ctrl_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int FTW_W   = FTW_W_DEF,
   parameter int NWORDS  = NWORDS_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   ftw_load_ctrl_if.slave   wr_if,
   input  logic             abort_i,
   input  logic             sync_pulse_i,
   output logic [FTW_W-1:0] ftw_out_o,
   output logic             ftw_en_o,
   output logic             busy_o,
   output logic             err_timeout_o,
   output logic [7:0]       commit_cnt_o
);
   localparam int IDX_W = $clog2(NWORDS);

   ftw_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [FTW_W-1:0] ftw_q, ftw_d;
   logic             ftw_en_q, ftw_en_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [7:0]       commit_q, commit_d;

   logic accept;
   logic wd_clr, wd_en, wd_tc;

`ifndef FTW_SYNC_COMMIT_EN
   logic unused_sync;
   assign unused_sync = sync_pulse_i;
`endif

   assign wr_if.wr_ready = (state_q == IDLE) || (state_q == COLLECT);
   assign accept         = wr_if.wr_valid && wr_if.wr_ready;

   word_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_word_timeout_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (wd_clr),
      .en_i  (wd_en),
      .tc_o  (wd_tc)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ftw_d    = ftw_q;
      commit_d = commit_q;
      err_d    = 1'b0;
      wd_clr   = 1'b1;
      wd_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               ftw_d[WORD_W-1:0] = wr_if.wr_data;
               idx_d             = IDX_W'(1);
               state_d           = COLLECT;
            end
         end
         COLLECT: begin
            wd_clr = 1'b0;
            if (abort_i) begin
               // abort wins over a coincident accept: the word is dropped
               wd_clr  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else if (accept) begin
               ftw_d[WORD_W*int'(idx_q) +: WORD_W] = wr_if.wr_data;
               wd_clr = 1'b1;
               if (idx_q == IDX_W'(NWORDS - 1)) begin
                  idx_d = '0;
`ifdef FTW_SYNC_COMMIT_EN
                  state_d = ARMED;
`else
                  state_d = COMMIT;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               wd_en = 1'b1;
               if (wd_tc) begin
                  err_d   = 1'b1;
                  idx_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         ARMED: begin
`ifdef FTW_SYNC_COMMIT_EN
            if (abort_i) begin
               state_d = IDLE;
            end else if (sync_pulse_i) begin
               state_d = COMMIT;
            end
`else
            state_d = IDLE;
`endif
         end
         COMMIT: begin
            commit_d = commit_q + 8'd1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // strobe and busy are registered from the next state so they line up
      // with the state they describe
      ftw_en_d = (state_d == COMMIT);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         ftw_q    <= '0;
         ftw_en_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         commit_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ftw_q    <= ftw_d;
         ftw_en_q <= ftw_en_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         commit_q <= commit_d;
      end
   end

   assign ftw_out_o     = ftw_q;
   assign ftw_en_o      = ftw_en_q;
   assign busy_o        = busy_q;
   assign err_timeout_o = err_q;
   assign commit_cnt_o  = commit_q;
endmodule

// File: tb/tb_ftw_load_ctrl.sv
// tb/tb_ftw_load_ctrl.sv - directed self-checking bench for ftw_load_ctrl
module tb_ftw_load_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        abort = 1'b0;
   logic        sync_pulse = 1'b0;
   logic [47:0] ftw_out;
   logic        ftw_en, busy, err_timeout;
   logic [7:0]  commit_cnt;

   int          checks = 0;
   int          errors = 0;
   int          en_pulses = 0;
   logic [7:0]  exp_commits = 8'd0;
   logic [47:0] latch_q = '0;

   ftw_load_ctrl_if #(.WORD_W(16)) wr_if ();

   ftw_load_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_if         (wr_if),
      .abort_i       (abort),
      .sync_pulse_i  (sync_pulse),
      .ftw_out_o     (ftw_out),
      .ftw_en_o      (ftw_en),
      .busy_o        (busy),
      .err_timeout_o (err_timeout),
      .commit_cnt_o  (commit_cnt)
   );

   always #5 clk = ~clk;

   // downstream FTW latch and strobe counter
   always @(posedge clk) if (ftw_en === 1'b1) latch_q <= ftw_out;
   always @(negedge clk) if (ftw_en === 1'b1) en_pulses++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_word(input logic [15:0] d);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = d;
      tick();
      wr_if.wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = '0;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (ftw_out !== 48'h0) begin errors++; $display("FAIL reset_ftw_out: got %h expected 0", ftw_out); end
      checks++; if (ftw_en !== 1'b0) begin errors++; $display("FAIL reset_ftw_en: got %b expected 0", ftw_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
      checks++; if (commit_cnt !== 8'd0) begin errors++; $display("FAIL reset_commit_cnt: got %0d expected 0", commit_cnt); end
      checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_if.wr_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_load();
      int p0 = en_pulses;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 16'h3333;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready_collect: got %b expected 1", wr_if.wr_ready); end
      wr_if.wr_data = 16'h2222;
      tick();
      checks++; if (ftw_en !== 1'b0) begin errors++; $display("FAIL single_early_en: got %b expected 0", ftw_en); end
      wr_if.wr_data = 16'h1111;
      tick();
      wr_if.wr_valid = 1'b0;
      checks++; if (ftw_en !== 1'b1) begin errors++; $display("FAIL single_en: got %b expected 1", ftw_en); end
      checks++; if (ftw_out !== 48'h1111_2222_3333) begin errors++; $display("FAIL single_ftw: got %h expected 111122223333", ftw_out); end
      checks++; if (wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL single_ready_commit: got %b expected 0", wr_if.wr_ready); end
      tick();
      exp_commits++;
      checks++; if (ftw_en !== 1'b0) begin errors++; $display("FAIL single_en_off: got %b expected 0", ftw_en); end
      checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after: got %b expected 1", wr_if.wr_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
      checks++; if (commit_cnt !== exp_commits) begin errors++; $display("FAIL single_commit_cnt: got %0d expected %0d", commit_cnt, exp_commits); end
      checks++; if (latch_q !== 48'h1111_2222_3333) begin errors++; $display("FAIL single_latch: got %h expected 111122223333", latch_q); end
      checks++; if (en_pulses !== p0 + 1) begin errors++; $display("FAIL single_pulses: got %0d expected %0d", en_pulses, p0 + 1); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream [7];
      stream[0] = 16'h3333; stream[1] = 16'h2222; stream[2] = 16'h1111;
      stream[3] = 16'hAAAA; stream[4] = 16'hAAAA; stream[5] = 16'hBBBB; stream[6] = 16'hCCCC;
      for (int i = 0; i < 8; i++) begin
         logic exp_en;
         exp_en = (i == 2) || (i == 6);
         wr_if.wr_valid = (i < 7);
         wr_if.wr_data  = (i < 7) ? stream[i] : 16'h0;
         tick();
         checks++; if (ftw_en !== exp_en) begin errors++; $display("FAIL b2b_en[%0d]: got %b expected %b", i, ftw_en, exp_en); end
         checks++; if (wr_if.wr_ready !== !exp_en) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, wr_if.wr_ready, !exp_en); end
         if (i == 2) begin
            checks++; if (ftw_out !== 48'h1111_2222_3333) begin errors++; $display("FAIL b2b_ftw0: got %h expected 111122223333", ftw_out); end
         end
         if (i == 6) begin
            checks++; if (ftw_out !== 48'hCCCC_BBBB_AAAA) begin errors++; $display("FAIL b2b_ftw1: got %h expected ccccbbbbaaaa", ftw_out); end
         end
      end
      wr_if.wr_valid = 1'b0;
      exp_commits = exp_commits + 8'd2;
      checks++; if (commit_cnt !== exp_commits) begin errors++; $display("FAIL b2b_commit_cnt: got %0d expected %0d", commit_cnt, exp_commits); end
   endtask

   task automatic test_gaps();
      logic [15:0] words [3];
      words[0] = 16'h5678; words[1] = 16'h1234; words[2] = 16'h9ABC;
      for (int w = 0; w < 2; w++) begin
         put_word(words[w]);
         for (int g = 0; g < 10; g++) begin
            tick();
            checks++; if (err_timeout !== 1'b0 || ftw_en !== 1'b0) begin errors++; $display("FAIL gap_quiet[%0d.%0d]: got err=%b en=%b expected 0 0", w, g, err_timeout, ftw_en); end
         end
      end
      put_word(words[2]);
      checks++; if (ftw_en !== 1'b1) begin errors++; $display("FAIL gap_en: got %b expected 1", ftw_en); end
      checks++; if (ftw_out !== 48'h9ABC_1234_5678) begin errors++; $display("FAIL gap_ftw: got %h expected 9abc12345678", ftw_out); end
      tick();
      exp_commits++;
      checks++; if (commit_cnt !== exp_commits) begin errors++; $display("FAIL gap_commit_cnt: got %0d expected %0d", commit_cnt, exp_commits); end
   endtask

   task automatic test_timeout();
      int p0 = en_pulses;
      put_word(16'h0001);
      put_word(16'h0002);
      repeat (254) tick();
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", err_timeout); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_before: got %b expected 1", busy); end
      tick();
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", err_timeout); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_after: got %b expected 0", busy); end
      tick();
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", err_timeout); end
      checks++; if (en_pulses !== p0) begin errors++; $display("FAIL to_no_commit: got %0d expected %0d", en_pulses, p0); end
      put_word(16'h4444);
      put_word(16'h5555);
      put_word(16'h6666);
      checks++; if (ftw_en !== 1'b1) begin errors++; $display("FAIL to_reload_en: got %b expected 1", ftw_en); end
      checks++; if (ftw_out !== 48'h6666_5555_4444) begin errors++; $display("FAIL to_reload_ftw: got %h expected 666655554444", ftw_out); end
      tick();
      exp_commits++;
      checks++; if (commit_cnt !== exp_commits) begin errors++; $display("FAIL to_commit_cnt: got %0d expected %0d", commit_cnt, exp_commits); end
   endtask

   task automatic test_abort();
      int p0 = en_pulses;
      put_word(16'h0007);
      put_word(16'h0008);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 16'h0009;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wr_if.wr_valid = 1'b0;
      checks++; if (ftw_en !== 1'b0) begin errors++; $display("FAIL abort_en: got %b expected 0", ftw_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      tick();
      checks++; if (en_pulses !== p0) begin errors++; $display("FAIL abort_pulses: got %0d expected %0d", en_pulses, p0); end
      checks++; if (commit_cnt !== exp_commits) begin errors++; $display("FAIL abort_commit_cnt: got %0d expected %0d", commit_cnt, exp_commits); end
      // abort has no effect in IDLE: the word is still taken
      abort = 1'b1;
      put_word(16'h000A);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_idle_ignored: got %b expected 1", busy); end
      tick();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_collect: got %b expected 0", busy); end
      put_word(16'h000A);
      put_word(16'h000B);
      put_word(16'h000C);
      checks++; if (ftw_en !== 1'b1 || ftw_out !== 48'h000C_000B_000A) begin errors++; $display("FAIL abort_reload: got en=%b ftw=%h expected 1 000c000b000a", ftw_en, ftw_out); end
      tick();
      exp_commits++;
   endtask

   task automatic test_reset_mid();
      put_word(16'hDEAD);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
      rst_n = 1'b0;
      #2;
      checks++; if (busy !== 1'b0 || ftw_en !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy=%b en=%b err=%b expected 0 0 0", busy, ftw_en, err_timeout); end
      checks++; if (ftw_out !== 48'h0) begin errors++; $display("FAIL rmid_ftw: got %h expected 0", ftw_out); end
      checks++; if (commit_cnt !== 8'd0) begin errors++; $display("FAIL rmid_commit_cnt: got %0d expected 0", commit_cnt); end
      checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", wr_if.wr_ready); end
      tick();
      rst_n = 1'b1;
      exp_commits = 8'd0;
      tick();
      put_word(16'hDEAD);
      put_word(16'hBEEF);
      put_word(16'h0123);
      checks++; if (ftw_en !== 1'b1 || ftw_out !== 48'h0123_BEEF_DEAD) begin errors++; $display("FAIL rmid_reload: got en=%b ftw=%h expected 1 0123beefdead", ftw_en, ftw_out); end
      tick();
      exp_commits++;
      checks++; if (commit_cnt !== exp_commits) begin errors++; $display("FAIL rmid_commit_cnt_after: got %0d expected %0d", commit_cnt, exp_commits); end
   endtask

`ifdef FTW_SYNC_COMMIT_EN
   task automatic test_sync();
      put_word(16'h0001);
      put_word(16'h0002);
      put_word(16'h0003);
      checks++; if (ftw_en !== 1'b0 || busy !== 1'b1 || wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL sync_armed: got en=%b busy=%b ready=%b expected 0 1 0", ftw_en, busy, wr_if.wr_ready); end
      repeat (19) tick();
      checks++; if (ftw_en !== 1'b0) begin errors++; $display("FAIL sync_wait: got %b expected 0", ftw_en); end
      sync_pulse = 1'b1;
      tick();
      sync_pulse = 1'b0;
      checks++; if (ftw_en !== 1'b1 || ftw_out !== 48'h0003_0002_0001) begin errors++; $display("FAIL sync_commit: got en=%b ftw=%h expected 1 000300020001", ftw_en, ftw_out); end
      tick();
      exp_commits++;
      put_word(16'h0004);
      put_word(16'h0005);
      sync_pulse = 1'b1;
      put_word(16'h0006);
      sync_pulse = 1'b0;
      checks++; if (ftw_en !== 1'b0) begin errors++; $display("FAIL sync_coincident: got %b expected 0", ftw_en); end
      tick();
      checks++; if (ftw_en !== 1'b0) begin errors++; $display("FAIL sync_coincident_hold: got %b expected 0", ftw_en); end
      sync_pulse = 1'b1;
      tick();
      sync_pulse = 1'b0;
      checks++; if (ftw_en !== 1'b1) begin errors++; $display("FAIL sync_next_pulse: got %b expected 1", ftw_en); end
      tick();
      exp_commits++;
      checks++; if (commit_cnt !== exp_commits) begin errors++; $display("FAIL sync_commit_cnt: got %0d expected %0d", commit_cnt, exp_commits); end
   endtask
`endif

   initial begin
      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = '0;
      test_reset();
      test_single_load();
      test_back_to_back();
      test_gaps();
      test_timeout();
      test_abort();
      test_reset_mid();
`ifdef FTW_SYNC_COMMIT_EN
      test_sync();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
